fifo_v5: RTL
============

Name: fifo_v5

Overview:
- Next-generation synchronous FIFO.
- Supports arbitrary depth, including non-power-of-2 depths.
- Reports a full-width occupancy count (no truncation when full).
- Provides programmable almost-full and almost-empty flags.
- Provides sticky overflow/underflow error flags; illegal pushes and pops are dropped safely.
- Used as the buffering element in bus bridges and interconnect wrappers. Drop-in for push/pop-style FIFOs, with added status.

Parameters:
- FALL_THROUGH, 0: 1 = data_i is forwarded to data_o combinationally when the FIFO is empty and push_i is high.
- DATA_WIDTH, 32: width of one entry.
- DEPTH, 8: number of entries, 2..65536, any integer.
- AF_THRESH, DEPTH-1: almost_full_o asserts when usage >= AF_THRESH. Valid range 1..DEPTH.
- AE_THRESH, 1: almost_empty_o asserts when usage <= AE_THRESH. Valid range 0..DEPTH-1.
- ADDR_W (derived, do not override): $clog2(DEPTH).
- CNT_W (derived, do not override): $clog2(DEPTH+1).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous clear of pointers and count; does not clear error flags.
- data_i  in  DATA_WIDTH  push data.
- push_i  in  1  push request.
- pop_i  in  1  pop request.
- data_o  out  DATA_WIDTH  head entry.
- full_o  out  1  usage == DEPTH.
- empty_o  out  1  no readable data.
- almost_full_o  out  1  usage >= AF_THRESH.
- almost_empty_o  out  1  usage <= AE_THRESH.
- usage_o  out  CNT_W  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a push was attempted while full_o was high.
- underflow_o  out  1  sticky: a pop was attempted while empty_o was high.
- err_clr_i  in  1  clears both sticky flags.
- peak_usage_o  out  CNT_W  high-water mark (see Optional Feature).

Behaviour:
- Reset (rst_i=1 at clock edge): pointers=0, usage=0, overflow/underflow=0, peak=0.
  - Resulting outputs: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0 (when AF_THRESH>0).
  - data_o shows storage content; storage is not reset, so data_o is don't-care while empty.
- Reset has priority over flush_i. flush_i has priority over push/pop.
- Push accepted iff push_i & ~full_o.
  - Entry written at wptr.
  - wptr advances; it wraps to 0 after DEPTH-1 (explicit compare, not a power-of-2 rollover).
  - usage +1.
- Pop accepted iff pop_i & ~empty_o. rptr advances with the same wrap rule; usage -1.
- Push and pop accepted in the same cycle: usage unchanged, both pointers advance.
- Full and push & pop in the same cycle: the pop is accepted, the push is rejected (full_o is registered-state based); overflow_o is set.
- Non-FALL_THROUGH mode:
  - data_o = mem[rptr].
  - Read latency 1 cycle: data pushed at edge N is visible after edge N.
  - empty_o = (usage==0).
- FALL_THROUGH mode, when usage==0 and push_i=1:
  - data_o=data_i and empty_o=0.
  - If pop_i is also high: no pointer or count change, no write (zero-latency pass-through).
- Flags (full_o, almost_*, usage_o) are registered-state derived. They never depend combinationally on push_i/pop_i, except empty_o in FALL_THROUGH mode.
- Sticky flags: set on the illegal attempt, held until err_clr_i or rst_i.
  - err_clr_i and a new illegal event in the same cycle: the flag stays set (set wins).
- Illegal requests never corrupt pointers, count or storage.
- Simulation-only assertions: DEPTH>=2, AF_THRESH in range, AE_THRESH in range.

Optional Feature:
- Macro: FIFO_V5_PEAK_USAGE_EN.
- Defined: peak_usage_o holds the maximum usage seen since reset/err_clr_i.
  - Updated one cycle after usage changes: peak <= max(peak, usage_q).
  - flush_i does not clear it.
- Not defined: peak_usage_o tied to 0; no extra flops.

Decomposition:
- Package fifo_v5_pkg:
  - function cnt_width(depth) returning $clog2(depth+1);
  - typedef fifo_status_t, a struct of {full, empty, almost_full, almost_empty, overflow, underflow} for wrapper use.
- One sub-module: fifo_v5_ptr.
  - Parameter DEPTH.
  - Ports: clk_i, rst_i, clr_i, inc_i, ptr_o.
  - Behaviour: wrap-at-DEPTH pointer; instantiated twice (read, write).

Test Plan:
- DEPTH=5, DATA_WIDTH=8: push 0x10..0x14 → full_o=1, usage_o=5. A 6th push of 0xFF → overflow_o=1, usage_o stays 5. Pop 5 → data_o sequence 0x10..0x14, empty_o=1.
- DEPTH=5: run 12 push/pop cycles at usage 2 → pointer wraps at 4→0, data order preserved, usage_o constant 2.
- AF_THRESH=4, AE_THRESH=1, DEPTH=5: usage 0→5 → almost_empty_o high for usage 0–1, almost_full_o high for usage 4–5.
- FALL_THROUGH=1, empty, push_i=pop_i=1, data_i=0xA5 → data_o=0xA5 in the same cycle, empty_o=0, usage_o stays 0.
- Pop while empty → underflow_o=1. err_clr_i pulsed alone → 0. err_clr_i coincident with a new pop-while-empty → stays 1.
- Usage 3, flush_i=1 → next cycle usage_o=0, empty_o=1, sticky flags unchanged.
- Usage 3, rst_i=1 → next cycle usage_o=0, flags cleared.
- FIFO_V5_PEAK_USAGE_EN defined: reach usage 4, then drain → peak_usage_o=4.

Source files
------------

// File: rtl/fifo_v5_pkg.sv
// fifo_v5_pkg: shared width helper and status bundle for fifo_v5 and its wrappers.
// Pure declarations; no timing or flow control of its own.
package fifo_v5_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_v5_ptr.sv
// fifo_v5_ptr: index into a DEPTH-entry ring, wrapping by explicit compare so any depth works.
// Advances one cycle after inc_i; clr_i wins over inc_i; no backpressure.
module fifo_v5_ptr #(
    parameter int DEPTH = 8,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_v5.sv
// fifo_v5: any-depth synchronous FIFO with occupancy, thresholds, sticky errors; FIFO_V5_PEAK_USAGE_EN adds high-water mark.
// Read latency 1 cycle (0 when FALL_THROUGH and empty); pushes dropped when full, pops when empty, both flagged sticky.
module fifo_v5
    import fifo_v5_pkg::*;
#(
    parameter int FALL_THROUGH = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int AF_THRESH    = DEPTH - 1,
    parameter int AE_THRESH    = 1,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int CNT_W       = cnt_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    input  logic                  err_clr_i,
    output logic [CNT_W-1:0]      peak_usage_o
);

    logic [ADDR_W-1:0]     wptr;
    logic [ADDR_W-1:0]     rptr;
    logic [CNT_W-1:0]      usage_q;
    logic [CNT_W-1:0]      usage_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  udf_q;
    logic                  udf_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic full;
    logic state_empty;
    logic ft_view;
    logic push_acc;
    logic pop_acc;
    logic wr_en;

    // ft_view: empty store with a push pending, so the incoming word is the head.
    always_comb begin
        full        = (usage_q == CNT_W'(DEPTH));
        state_empty = (usage_q == '0);
        ft_view     = (FALL_THROUGH != 0) && state_empty && push_i;
        push_acc    = push_i && !full && !(ft_view && pop_i);
        pop_acc     = pop_i && !state_empty;
        wr_en       = push_acc && !flush_i;

        usage_d = usage_q;
        if (flush_i) begin
            usage_d = '0;
        end else if (push_acc && !pop_acc) begin
            usage_d = usage_q + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
            usage_d = usage_q - CNT_W'(1);
        end

        ovf_d = (ovf_q && !err_clr_i) || (push_i && full);
        udf_d = (udf_q && !err_clr_i) || (pop_i && empty_o);
    end

    fifo_v5_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (wr_en),
        .ptr_o (wptr)
    );

    fifo_v5_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (pop_acc),
        .ptr_o (rptr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            usage_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            usage_q <= usage_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem_q[wptr] <= data_i;
        end
    end

`ifdef FIFO_V5_PEAK_USAGE_EN
    logic [CNT_W-1:0] peak_q;
    logic [CNT_W-1:0] peak_d;

    always_comb begin
        peak_d = peak_q;
        if (err_clr_i) begin
            peak_d = '0;
        end else if (usage_q > peak_q) begin
            peak_d = usage_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_usage_o = peak_q;
`else
    assign peak_usage_o = '0;
`endif

    assign data_o         = ft_view ? data_i : mem_q[rptr];
    assign full_o         = full;
    assign empty_o        = state_empty && !ft_view;
    assign almost_full_o  = (usage_q >= CNT_W'(AF_THRESH));
    assign almost_empty_o = (usage_q <= CNT_W'(AE_THRESH));
    assign usage_o        = usage_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

    always_ff @(posedge clk_i) begin
        assert (DEPTH >= 2);
        assert (AF_THRESH >= 1 && AF_THRESH <= DEPTH);
        assert (AE_THRESH >= 0 && AE_THRESH <= DEPTH - 1);
    end

endmodule
